// File: rtl/map_bus_host_if.sv
// map_bus: shared bus between the cartridge host block and the selected mapper.
// The host drives the sampled CPU/PPU cycle fields and the mapper config;
// the mapper answers with memory addresses, enables and CIRAM controls.
interface map_bus #(
   parameter int ADDR_BITS = 22
);
   logic [15:0]          cpu_addr;
   logic                 cpu_rw;
   logic [13:0]          ppu_addr;
   logic                 ppu_rd;
   logic                 ppu_wr;
   logic [7:0]           args;
   logic                 prg_oe;
   logic [ADDR_BITS-1:0] prg_addr;
   logic                 chr_ce;
   logic                 chr_oe;
   logic                 chr_we;
   logic [ADDR_BITS-1:0] chr_addr;
   logic                 ciram_ce;
   logic                 ciram_a10;

   modport host (
      output cpu_addr, cpu_rw, ppu_addr, ppu_rd, ppu_wr, args,
      input  prg_oe, prg_addr, chr_ce, chr_oe, chr_we, chr_addr, ciram_ce, ciram_a10
   );

   modport mapper (
      input  cpu_addr, cpu_rw, ppu_addr, ppu_rd, ppu_wr, args,
      output prg_oe, prg_addr, chr_ce, chr_oe, chr_we, chr_addr, ciram_ce, ciram_a10
   );
endinterface

// File: rtl/map_bus_host.sv
// map_bus_host: synchronizes cartridge-edge pins, publishes them on map_bus,
// and converts mapper PRG/CHR decisions into single-beat memory requests.
// Optional feature macro: MAP_BUS_HOST_LATE_CNT_EN enables the late/dropped
// access counter; without it late_cnt is tied to 0.
module map_bus_host #(
   parameter int ADDR_BITS   = 22,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 m2,
   input  logic [15:0]          cpu_addr,
   input  logic                 cpu_rw,
   input  logic [13:0]          ppu_addr,
   input  logic                 ppu_rd_n,
   input  logic                 ppu_wr_n,
   input  logic [7:0]           ppu_din,
   input  logic [7:0]           mapper_args,
   map_bus.host                 bus,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   input  logic                 mem_ack,
   input  logic [7:0]           mem_rdata,
   output logic [7:0]           cpu_dout,
   output logic                 cpu_doe,
   output logic [7:0]           ppu_dout,
   output logic                 ppu_doe,
   output logic                 ciram_ce,
   output logic                 ciram_a10,
   output logic [7:0]           late_cnt
);
   // All pins share one synchronizer chain so a strobe and its address
   // emerge from the chain on the same cycle.
   localparam int PIN_W = 42;
   localparam logic [PIN_W-1:0] PIN_IDLE = {1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 14'h0000, 8'h00};

   typedef enum logic {IDLE, ISSUE} state_t;

   logic [PIN_W-1:0]                  pin_vec;
   logic [SYNC_STAGES-1:0][PIN_W-1:0] sync_reg;
   logic [PIN_W-1:0]                  pin_s;
   logic                              m2_s, rw_s, rd_n_s, wr_n_s;
   logic [15:0]                       caddr_s;
   logic [13:0]                       paddr_s;
   logic [7:0]                        din_s;

   logic m2_prev, rd_n_prev, wr_n_prev;
   logic cpu_evt_reg, rd_evt_reg, wr_evt_reg;
   logic dec_cpu_reg, dec_rd_reg, dec_wr_reg;
   logic cpu_req_now, ppu_rd_now, ppu_wr_now, ppu_req_now;

   logic                 cpu_pend_reg, ppu_pend_reg, ppu_pwe_reg, cur_ppu_reg;
   logic [ADDR_BITS-1:0] cpu_paddr_reg, ppu_paddr_reg;
   logic [7:0]           ppu_pdata_reg;

   state_t state_reg, state_next;
   logic   take_ppu, take_cpu, ack_now;

   assign pin_vec = {m2, cpu_rw, ppu_rd_n, ppu_wr_n, cpu_addr, ppu_addr, ppu_din};
   assign pin_s   = sync_reg[SYNC_STAGES-1];
   assign m2_s    = pin_s[41];
   assign rw_s    = pin_s[40];
   assign rd_n_s  = pin_s[39];
   assign wr_n_s  = pin_s[38];
   assign caddr_s = pin_s[37:22];
   assign paddr_s = pin_s[21:8];
   assign din_s   = pin_s[7:0];

   // Synchronizer chain for every pin input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_reg <= {SYNC_STAGES{PIN_IDLE}};
      else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin_vec};
   end

   // Edge detection on synchronized strobes, registered as one-cycle events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m2_prev     <= 1'b0;
         rd_n_prev   <= 1'b1;
         wr_n_prev   <= 1'b1;
         cpu_evt_reg <= 1'b0;
         rd_evt_reg  <= 1'b0;
         wr_evt_reg  <= 1'b0;
         dec_cpu_reg <= 1'b0;
         dec_rd_reg  <= 1'b0;
         dec_wr_reg  <= 1'b0;
      end else begin
         m2_prev     <= m2_s;
         rd_n_prev   <= rd_n_s;
         wr_n_prev   <= wr_n_s;
         cpu_evt_reg <= m2_s & ~m2_prev;
         rd_evt_reg  <= ~rd_n_s & rd_n_prev;
         wr_evt_reg  <= ~wr_n_s & wr_n_prev;
         dec_cpu_reg <= cpu_evt_reg;
         dec_rd_reg  <= rd_evt_reg;
         dec_wr_reg  <= wr_evt_reg;
      end
   end

   // Bus registers: addresses move only on events, strobe levels always track.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.cpu_addr <= 16'h0000;
         bus.cpu_rw   <= 1'b1;
         bus.ppu_addr <= 14'h0000;
         bus.ppu_rd   <= 1'b1;
         bus.ppu_wr   <= 1'b1;
         bus.args     <= 8'h00;
         ciram_ce     <= 1'b0;
         ciram_a10    <= 1'b0;
      end else begin
         if (cpu_evt_reg) begin
            bus.cpu_addr <= caddr_s;
            bus.cpu_rw   <= rw_s;
         end
         if (rd_evt_reg || wr_evt_reg) bus.ppu_addr <= paddr_s;
         bus.ppu_rd <= rd_n_s;
         bus.ppu_wr <= wr_n_s;
         bus.args   <= mapper_args;
         ciram_ce   <= bus.ciram_ce;
         ciram_a10  <= bus.ciram_a10;
      end
   end

   // The mapper has had one cycle to decode the captured cycle.
   assign cpu_req_now = dec_cpu_reg & bus.prg_oe;
   assign ppu_rd_now  = dec_rd_reg & bus.chr_ce & bus.chr_oe;
   assign ppu_wr_now  = dec_wr_reg & bus.chr_ce & bus.chr_we;
   assign ppu_req_now = ppu_rd_now | ppu_wr_now;

   // Pending requests; a newer decision overwrites a not-yet-issued one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_pend_reg  <= 1'b0;
         cpu_paddr_reg <= '0;
         ppu_pend_reg  <= 1'b0;
         ppu_paddr_reg <= '0;
         ppu_pwe_reg   <= 1'b0;
         ppu_pdata_reg <= 8'h00;
      end else begin
         if (cpu_req_now) begin
            cpu_pend_reg  <= 1'b1;
            cpu_paddr_reg <= bus.prg_addr;
         end else if (take_cpu) begin
            cpu_pend_reg <= 1'b0;
         end
         if (ppu_req_now) begin
            ppu_pend_reg  <= 1'b1;
            ppu_paddr_reg <= bus.chr_addr;
            ppu_pwe_reg   <= ppu_wr_now;
            ppu_pdata_reg <= din_s;
         end else if (take_ppu) begin
            ppu_pend_reg <= 1'b0;
         end
      end
   end

   // Request FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next state and arbitration: PPU beats CPU when both are pending.
   always_comb begin
      state_next = state_reg;
      take_ppu   = 1'b0;
      take_cpu   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ppu_pend_reg) begin
               state_next = ISSUE;
               take_ppu   = 1'b1;
            end else if (cpu_pend_reg) begin
               state_next = ISSUE;
               take_cpu   = 1'b1;
            end
         end
         ISSUE: if (mem_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign mem_req = (state_reg == ISSUE);
   assign ack_now = (state_reg == ISSUE) & mem_ack;

   // Request payload, held stable for the whole ISSUE state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= 8'h00;
         cur_ppu_reg <= 1'b0;
      end else if (take_ppu) begin
         mem_we      <= ppu_pwe_reg;
         mem_addr    <= ppu_paddr_reg;
         mem_wdata   <= ppu_pdata_reg;
         cur_ppu_reg <= 1'b1;
      end else if (take_cpu) begin
         mem_we      <= 1'b0;
         mem_addr    <= cpu_paddr_reg;
         mem_wdata   <= 8'h00;
         cur_ppu_reg <= 1'b0;
      end
   end

   // Read return: drive data only while the originating pin cycle is open.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_dout <= 8'h00;
         cpu_doe  <= 1'b0;
         ppu_dout <= 8'h00;
         ppu_doe  <= 1'b0;
      end else begin
         if (!m2_s)  cpu_doe <= 1'b0;
         if (rd_n_s) ppu_doe <= 1'b0;
         if (ack_now && !mem_we) begin
            if (cur_ppu_reg && !rd_n_s) begin
               ppu_dout <= mem_rdata;
               ppu_doe  <= 1'b1;
            end else if (!cur_ppu_reg && m2_s) begin
               cpu_dout <= mem_rdata;
               cpu_doe  <= 1'b1;
            end
         end
      end
   end

`ifdef MAP_BUS_HOST_LATE_CNT_EN
   logic       ack_late, cpu_overrun, ppu_overrun;
   logic [1:0] late_inc;
   logic [8:0] late_sum;
   logic [7:0] late_reg;

   assign ack_late    = ack_now & ~mem_we & (cur_ppu_reg ? rd_n_s : ~m2_s);
   assign cpu_overrun = cpu_req_now & cpu_pend_reg & ~take_cpu;
   assign ppu_overrun = ppu_req_now & ppu_pend_reg & ~take_ppu;
   assign late_inc    = 2'(ack_late) + 2'(cpu_overrun) + 2'(ppu_overrun);
   assign late_sum    = {1'b0, late_reg} + {7'd0, late_inc};
   assign late_cnt    = late_reg;

   // Saturating count of discarded reads and overwritten requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            late_reg <= 8'h00;
      else if (late_sum[8])  late_reg <= 8'hFF;
      else                   late_reg <= late_sum[7:0];
   end
`else
   assign late_cnt = 8'h00;
`endif

endmodule
